// File: rtl/serial_pkg.sv
// Shared types and constants for the serial inference frame controller.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_PIX   = 3'd1,
        ST_CLASSIFY = 3'd2,
        ST_TX_RES   = 3'd3,
        ST_TX_MATCH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TX_WAIT_RDY  = 2'd0,
        TX_WAIT_LOW  = 2'd1,
        TX_WAIT_HIGH = 2'd2
    } tx_phase_t;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_Y   = 8'h59;
    localparam logic [7:0] ASCII_N   = 8'h4E;
    localparam logic [7:0] MAX_LABEL = 8'd9;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_0 + {4'd0, d};
    endfunction

endpackage

// File: rtl/serial_frame_ctrl_pixel_assembler.sv
// Byte strobe detection and little-endian pixel assembly; issues one image
// buffer write per completed pixel in x-fastest raster order.
module pixel_assembler #(
    parameter int IMG_W         = 28,
    parameter int IMG_H         = 28,
    parameter int BYTES_PER_PIX = 4,
    parameter int ADDR_W        = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_ready,
    input  logic [7:0]                   rx_data,
    input  logic                         accept,
    input  logic                         clear,
    output logic                         strobe,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [8*BYTES_PER_PIX-1:0]   wr_data,
    output logic                         pix_done
);

    localparam int IW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic                       rx_ready_q, rx_ready_d;
    logic [IW-1:0]              byte_idx_q, byte_idx_d;
    logic [8*BYTES_PER_PIX-1:0] acc_q, acc_d;
    logic                       wr_en_q, wr_en_d;
    logic [XW-1:0]              x_q, x_d;
    logic [YW-1:0]              y_q, y_d;
    logic                       take;

    assign strobe = rx_ready & ~rx_ready_q;
    assign take   = strobe & accept;

    always_comb begin
        rx_ready_d = rx_ready;
        byte_idx_d = byte_idx_q;
        // The accumulator empties in the write cycle, but a byte landing in
        // that same cycle still belongs to the next pixel.
        acc_d      = wr_en_q ? '0 : acc_q;
        wr_en_d    = 1'b0;
        x_d        = x_q;
        y_d        = y_q;

        if (wr_en_q) begin
            if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        if (take) begin
            acc_d[8*byte_idx_q +: 8] = rx_data;
            if (byte_idx_q == IW'(BYTES_PER_PIX - 1)) begin
                byte_idx_d = '0;
                wr_en_d    = 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + IW'(1);
            end
        end

        if (clear) begin
            byte_idx_d = '0;
            acc_d      = '0;
            wr_en_d    = 1'b0;
            x_d        = '0;
            y_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
            byte_idx_q <= '0;
            acc_q      <= '0;
            wr_en_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            rx_ready_q <= rx_ready_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
            wr_en_q    <= wr_en_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = acc_q;
    assign wr_addr  = ADDR_W'(y_q) * ADDR_W'(IMG_W) + ADDR_W'(x_q);
    assign pix_done = wr_en_q && (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

endmodule

// File: rtl/serial_frame_ctrl.sv
// Sequences one inference transaction: label byte, pixel stream into the
// image buffer, classifier request, then result digit and Y/N over the UART.
module serial_frame_ctrl
    import serial_pkg::*;
#(
    parameter int IMG_W          = 28,
    parameter int IMG_H          = 28,
    parameter int BYTES_PER_PIX  = 4,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       rx_ready,
    input  logic [7:0]                 rx_data,
    input  logic                       tx_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [8*BYTES_PER_PIX-1:0] wr_data,
    output logic                       cls_start,
    input  logic                       cls_done,
    input  logic [3:0]                 cls_label,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       match,
    output logic                       err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    tx_phase_t     phase_q, phase_d;
    logic [3:0]    label_q, label_d;
    logic [3:0]    res_q, res_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          cls_start_q, cls_start_d;
    logic          frame_done_q, frame_done_d;
    logic          match_q, match_d;
    logic          err_q, err_d;

    logic          strobe;
    logic          pix_done;
    logic          asm_clear;

    pixel_assembler #(
        .IMG_W         (IMG_W),
        .IMG_H         (IMG_H),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .ADDR_W        (ADDR_W)
    ) u_asm (
        .clk      (sys_clk),
        .rst_n    (rst),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .accept   (state_q == ST_RX_PIX),
        .clear    (asm_clear),
        .strobe   (strobe),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pix_done (pix_done)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        label_d      = label_q;
        res_d        = res_q;
        timer_d      = '0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        cls_start_d  = 1'b0;
        frame_done_d = frame_done_q;
        match_d      = match_q;
        err_d        = err_q;
        asm_clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    if (rx_data <= MAX_LABEL) begin
                        label_d      = rx_data[3:0];
                        frame_done_d = 1'b0;
                        state_d      = ST_RX_PIX;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_RX_PIX: begin
                // A strobe always beats a coincident timeout.
                if (pix_done) begin
                    state_d      = ST_CLASSIFY;
                    cls_start_d  = 1'b1;
                    frame_done_d = 1'b1;
                end else if (strobe) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    err_d     = 1'b1;
                    asm_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_CLASSIFY: begin
                if (strobe) begin
                    err_d = 1'b1;
                end
                if (cls_done) begin
                    res_d   = cls_label;
                    match_d = (cls_label == label_q);
                    state_d = ST_TX_RES;
                    phase_d = TX_WAIT_RDY;
                end
            end

            ST_TX_RES, ST_TX_MATCH: begin
                if (strobe) begin
                    err_d = 1'b1;
                end
                case (phase_q)
                    TX_WAIT_RDY: begin
                        if (tx_ready) begin
                            tx_start_d = 1'b1;
                            tx_data_d  = (state_q == ST_TX_RES) ? ascii_digit(res_q)
                                                                : (match_q ? ASCII_Y : ASCII_N);
                            phase_d    = TX_WAIT_LOW;
                        end
                    end
                    TX_WAIT_LOW: begin
                        if (!tx_ready) begin
                            phase_d = TX_WAIT_HIGH;
                        end
                    end
                    TX_WAIT_HIGH: begin
                        if (tx_ready) begin
                            phase_d = TX_WAIT_RDY;
                            state_d = (state_q == ST_TX_RES) ? ST_TX_MATCH : ST_IDLE;
                        end
                    end
                    default: phase_d = TX_WAIT_RDY;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= TX_WAIT_RDY;
            label_q      <= '0;
            res_q        <= '0;
            timer_q      <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            cls_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            match_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            label_q      <= label_d;
            res_q        <= res_d;
            timer_q      <= timer_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            cls_start_q  <= cls_start_d;
            frame_done_q <= frame_done_d;
            match_q      <= match_d;
            err_q        <= err_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign cls_start  = cls_start_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign match      = match_q;
    assign err        = err_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Randomized frame-level bench: UART and classifier are modelled reactively,
// every expectation comes from the frame protocol rules.
module tb_serial_frame_ctrl;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int TO    = 64;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cls_start;
    logic        cls_done = 1'b0;
    logic [3:0]  cls_label = 4'd0;
    logic        busy, frame_done, match, err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [7:0]  tx_q[$];
    int          cls_start_cnt = 0;
    int          cls_start_cyc = 0;
    int          cls_delay = 0;
    int          cls_cnt = 0;
    logic [3:0]  cls_result = 4'd0;
    int          tx_cnt = 0;
    logic [31:0] exp_pix [NPIX];

    serial_frame_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cls_start  (cls_start),
        .cls_done   (cls_done),
        .cls_label  (cls_label),
        .busy       (busy),
        .frame_done (frame_done),
        .match      (match),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitors plus reactive uart_tx and classifier models, all on the falling edge.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (wr_en) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
                wc_q.push_back(cyc);
            end
            if (tx_start) tx_q.push_back(tx_data);
            cls_done = 1'b0;
            if (cls_start) begin
                cls_start_cnt++;
                cls_start_cyc = cyc;
                cls_cnt = cls_delay + 1;
            end
            if (cls_cnt > 0) begin
                cls_cnt--;
                if (cls_cnt == 0) begin
                    cls_done  = 1'b1;
                    cls_label = cls_result;
                end
            end
            if (tx_start) begin
                tx_ready = 1'b0;
                tx_cnt   = $urandom_range(3, 8);
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_ready = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int rcyc);
        @(negedge sys_clk);
        rx_data  = b;
        rx_ready = 1'b1;
        rcyc     = cyc;
        @(negedge sys_clk);
        rx_ready = 1'b0;
        if ($urandom_range(0, 1) == 1) @(negedge sys_clk);
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        tx_q.delete();
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        cls_cnt  = 0;
        tx_cnt   = 0;
        tx_ready = 1'b1;
        rst = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic run_frame(input logic [3:0] label, input logic [3:0] res,
                             input int mode, input bit overrun, input string name);
        int rc, b4cyc, start_cnt, t, last;
        logic [31:0] pix;
        logic [15:0] idx;
        logic [7:0]  b;
        logic [7:0]  exp_tx0, exp_tx1;
        logic [9:0]  exp_addr;
        clear_logs();
        cls_result = res;
        start_cnt  = cls_start_cnt;
        b4cyc      = 0;
        send_byte({4'd0, label}, rc);
        n_vec++;
        if (frame_done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s label_accept: frame_done=%b busy=%b, required 0/1", name, frame_done, busy);
        end
        for (int p = 0; p < NPIX; p++) begin
            idx = p[15:0];
            if (mode == 0) pix = {8'h3C, 8'hA5, idx[15:8], idx[7:0]};
            else           pix = $urandom;
            exp_pix[p] = pix;
            for (int k = 0; k < 4; k++) begin
                b = pix[8*k +: 8];
                send_byte(b, rc);
                if (p == 0 && k == 3) b4cyc = rc;
            end
        end
        if (overrun) begin
            t = 0;
            while (cls_start_cnt == start_cnt && t < 20) begin
                @(negedge sys_clk);
                t++;
            end
            for (int k = 0; k < 3; k++) send_byte(8'($urandom), rc);
            n_vec++;
            if (busy !== 1'b1 || err !== 1'b1) begin
                n_bad++;
                $display("FAIL %s overrun: busy=%b err=%b, required 1/1", name, busy, err);
            end
        end
        wait_idle(4000, name);

        n_vec++;
        if (wa_q.size() != NPIX) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wa_q.size(), NPIX);
        end
        for (int p = 0; p < NPIX && p < wa_q.size(); p++) begin
            exp_addr = 10'((p / IMG_W) * IMG_W + (p % IMG_W));
            n_vec++;
            if (wa_q[p] !== exp_addr || wd_q[p] !== exp_pix[p]) begin
                n_bad++;
                $display("FAIL %s write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                         name, p, wa_q[p], wd_q[p], exp_addr, exp_pix[p]);
            end
        end
        if (wc_q.size() > 0) begin
            last = wc_q[wc_q.size()-1];
            n_vec++;
            if (wc_q[0] - b4cyc != 1) begin
                n_bad++;
                $display("FAIL %s wr_latency: got %0d cycles, required 1", name, wc_q[0] - b4cyc);
            end
            n_vec++;
            if (cls_start_cnt - start_cnt != 1 || cls_start_cyc - last != 1) begin
                n_bad++;
                $display("FAIL %s cls_start: pulses=%0d latency=%0d, required 1/1",
                         name, cls_start_cnt - start_cnt, cls_start_cyc - last);
            end
        end
        exp_tx0 = 8'h30 + {4'd0, res};
        exp_tx1 = (res == label) ? 8'h59 : 8'h4E;
        n_vec++;
        if (tx_q.size() != 2) begin
            n_bad++;
            $display("FAIL %s tx_count: got %0d bytes, required 2", name, tx_q.size());
        end else if (tx_q[0] !== exp_tx0 || tx_q[1] !== exp_tx1) begin
            n_bad++;
            $display("FAIL %s tx_bytes: got %h %h, required %h %h", name, tx_q[0], tx_q[1], exp_tx0, exp_tx1);
        end
        n_vec++;
        if (match !== (res == label) || frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s result: match=%b frame_done=%b, required %b/1", name, match, frame_done, (res == label));
        end
        $display("frame %s: label=%0d res=%0d writes=%0d tx=%0d", name, label, res, wa_q.size(), tx_q.size());
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        n_vec++;
        if ({tx_start, tx_data, wr_en, wr_addr, wr_data, cls_start, busy, frame_done, match, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: outputs=%h, required 0",
                     {tx_start, tx_data, wr_en, wr_addr, wr_data, cls_start, busy, frame_done, match, err});
        end
        rst = 1'b1;
        @(negedge sys_clk);
        $display("reset: released");
    endtask

    task automatic test_full_frame();
        cls_delay = $urandom_range(0, 5);
        run_frame(4'd7, 4'd7, 0, 1'b0, "full_frame");
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL full_frame err: got %b, required 0", err);
        end
    endtask

    task automatic test_mismatch();
        cls_delay = 0;
        run_frame(4'd3, 4'd5, 1, 1'b0, "mismatch");
        n_vec++;
        if (err !== 1'b0 || match !== 1'b0) begin
            n_bad++;
            $display("FAIL mismatch flags: err=%b match=%b, required 0/0", err, match);
        end
    endtask

    task automatic test_invalid_label();
        int rc;
        do_reset();
        clear_logs();
        send_byte(8'h41, rc);
        repeat (3) @(negedge sys_clk);
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0 || wa_q.size() != 0) begin
            n_bad++;
            $display("FAIL invalid_label: err=%b busy=%b writes=%0d, required 1/0/0", err, busy, wa_q.size());
        end
        $display("invalid_label: err=%b busy=%b", err, busy);
        cls_delay = $urandom_range(0, 5);
        run_frame(4'd2, 4'($urandom_range(0, 9)), 1, 1'b0, "after_invalid");
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL after_invalid err: got %b, required sticky 1", err);
        end
    endtask

    task automatic test_timeout();
        int rc;
        logic [31:0] pix [2];
        logic [7:0]  b;
        do_reset();
        clear_logs();
        send_byte(8'd1, rc);
        for (int p = 0; p < 2; p++) begin
            pix[p] = $urandom;
            for (int k = 0; k < 4; k++) begin
                b = pix[p][8*k +: 8];
                send_byte(b, rc);
            end
        end
        send_byte(8'($urandom), rc);
        send_byte(8'($urandom), rc);
        repeat (TO + 10) @(negedge sys_clk);
        n_vec++;
        if (wa_q.size() != 2 || err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout: writes=%0d err=%b busy=%b, required 2/1/0", wa_q.size(), err, busy);
        end else begin
            n_vec++;
            if (wa_q[0] !== 10'd0 || wa_q[1] !== 10'd1 || wd_q[0] !== pix[0] || wd_q[1] !== pix[1]) begin
                n_bad++;
                $display("FAIL timeout_writes: %0d:%h %0d:%h, required 0:%h 1:%h",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1], pix[0], pix[1]);
            end
        end
        $display("timeout: writes=%0d err=%b", wa_q.size(), err);
        cls_delay = $urandom_range(0, 5);
        run_frame(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1, 1'b0, "after_timeout");
    endtask

    task automatic test_overrun();
        do_reset();
        cls_delay = 20;
        run_frame(4'd4, 4'd4, 1, 1'b1, "overrun");
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun err: got %b, required 1", err);
        end
        cls_delay = 0;
    endtask

    task automatic test_reset_mid_frame();
        int rc;
        logic [7:0] b;
        clear_logs();
        send_byte(8'd6, rc);
        for (int i = 0; i < 400 * 4 + 2; i++) begin
            b = 8'($urandom);
            send_byte(b, rc);
        end
        @(negedge sys_clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({tx_start, tx_data, wr_en, wr_addr, wr_data, cls_start, busy, frame_done, match, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: outputs=%h, required 0",
                     {tx_start, tx_data, wr_en, wr_addr, wr_data, cls_start, busy, frame_done, match, err});
        end
        repeat (3) @(negedge sys_clk);
        n_vec++;
        if (wa_q.size() != 400) begin
            n_bad++;
            $display("FAIL reset_mid_writes: got %0d, required 400", wa_q.size());
        end
        $display("reset_mid_frame: writes before reset=%0d", wa_q.size());
        rst = 1'b1;
        @(negedge sys_clk);
        run_frame(4'd6, 4'd6, 1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_mismatch();
        test_invalid_label();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
